cam_to_world: RTL
=================

Name: cam_to_world

Overview:
- Inverse of the world-to-camera vertex translation stage. Adds the camera position back onto a camera-relative triangle (three 8-bit signed vertices) to recover world-space coordinates, saturated to 6-bit signed.
- Sits after camera-space processing and before any stage that compares against the world-space model store.
- Valid/ready on input and output.
- Shares a single saturating vector adder across the three vertices, one vertex per cycle.

Parameters:
- IN_W, 8, signed width of camera-relative vertex components
- POS_W, 7, signed width of camera position components
- OUT_W, 6, signed width of world-space output components

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- cam_pos_in[2:0]  input  POS_W signed each  camera position (x,y,z)
- cam_load_in  input  1  request to load cam_pos_in into the working camera register
- tri_valid_in  input  1  input triangle valid
- tri_ready_out  output  1  block can accept a triangle
- v1_in[2:0], v2_in[2:0], v3_in[2:0]  input  IN_W signed each  camera-relative vertices
- tri_valid_out  output  1  output triangle valid
- tri_ready_in  input  1  downstream accepts output
- v1_out[2:0], v2_out[2:0], v3_out[2:0]  output  OUT_W signed each  world-space vertices
- clip_out  output  1  at least one component of this triangle saturated; qualified by tri_valid_out
- busy_out  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk_in. rst_n_in is asynchronous and active-low.
- Reset (rst_n_in low): state=IDLE; cam_q=0; pending=0; idx=0.
  - All v*_out=0; tri_valid_out=0; clip_out=0; busy_out=0.
  - tri_ready_out forced 0 while rst_n_in is low.
- FSM states:
  - IDLE: tri_ready_out=1.
    - On edge with tri_valid_in&tri_ready_out, capture v1_in..v3_in into input regs, clear clip accumulator, idx=0, go ADD.
  - ADD: one vertex per edge, in order idx 0→1→2 (v1, v2, v3).
    - Sum = sext(v[idx], IN_W+2) + sext(cam_q, IN_W+2).
    - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] = [-32, 31].
    - Write the result into the output reg for that vertex; OR any saturation into the clip accumulator.
    - After the idx=2 edge, go HOLD.
  - HOLD: tri_valid_out=1. Outputs and clip_out stable until tri_valid_out&tri_ready_in.
    - On that edge, go IDLE and drop tri_valid_out.
    - v*_out retain their last values after the handshake.
- Latency: accept at edge k; tri_valid_out high after edge k+3. Minimum 5 cycles between accepts (no HOLD→accept bypass).
- Camera register:
  - cam_load_in in IDLE: cam_q<=cam_pos_in on that edge.
  - If a triangle is accepted on the same edge, that triangle uses the new cam_pos_in.
  - cam_load_in in ADD/HOLD: latch cam_pos_in into pend_q, set pending. A later load overwrites pend_q.
  - On the HOLD→IDLE edge with pending set: cam_q<=pend_q, pending<=0.
  - The in-flight triangle always completes with the cam_q it started with.
- Backpressure: while in HOLD, tri_valid_in is ignored (tri_ready_out=0). tri_ready_in is ignored outside HOLD.
- Reset mid-operation: immediate return to reset values. The partial triangle is discarded and no output valid is produced.
- Widths: no wrap-around anywhere. Intermediate sum is IN_W+2 = 10 bits signed, which cannot overflow.

Decomposition:
- Shared package (e.g. geom_pkg):
  - Width constants: IN_W, POS_W, OUT_W.
  - Typedefs: vec3_cam_t (3×IN_W signed), vec3_pos_t (3×POS_W signed), vec3_world_t (3×OUT_W signed).
  - Saturation limit constants.
  - FSM state enum: IDLE, ADD, HOLD.
- Sub-module vec3_add_sat: purely combinational, 3-lane sign-extend/add/saturate with a per-lane sat flag OR-reduced to one bit. Instantiated once, muxed by idx.

Test Plan:
- Identity: cam_pos=(10,-5,3) loaded; v1=(-10,5,-3), v2=(0,0,0), v3=(21,-26,28) → v1_out=(0,0,0), v2_out=(10,-5,3), v3_out=(31,-31,31), clip_out=0; tri_valid_out rises 3 edges after accept.
- Saturation: cam_pos=(63,-64,0); v1=(100,-128,31), v2=(-128,127,-32), v3=(1,1,1) → v1_out=(31,-32,31), v2_out=(-32,31,-32), v3_out=(31,-32,1), clip_out=1.
- Backpressure: tri_ready_in low for 4 cycles in HOLD → outputs constant, tri_ready_out=0, a second tri_valid_in is not accepted; accepted on the 2nd edge after tri_ready_in rises (HOLD→IDLE, then IDLE accept).
- Camera update during ADD: cam_q=(1,1,1), load (5,5,5) mid-triangle → current triangle uses (1,1,1); next triangle with v1=(0,0,0) gives (5,5,5). Also: load and accept on the same IDLE edge → new value used.
- Reset mid-ADD: drop rst_n_in after the idx=1 edge → all outputs 0 asynchronously, tri_valid_out never rises. After release, a fresh triangle completes correctly with cam_q=0.
- Back-to-back stream of 20 random triangles with random tri_ready_in → scoreboard matches the saturating reference model; 5-cycle minimum spacing respected; no lost or duplicated triangles.

Source files
------------

// File: rtl/cam_to_world_pkg.sv
// Shared widths, vector types and FSM states for the camera-to-world translation stage.
package cam_to_world_pkg;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned POS_W = 7;
  localparam int unsigned OUT_W = 6;
  localparam int unsigned SUM_W = IN_W + 2;

  // Saturation limits expressed at the intermediate sum width
  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(-(2 ** (OUT_W - 1)));

  typedef logic signed [IN_W-1:0]  cam_comp_t;
  typedef logic signed [POS_W-1:0] pos_comp_t;
  typedef logic signed [OUT_W-1:0] world_comp_t;

  typedef cam_comp_t   [2:0] vec3_cam_t;
  typedef pos_comp_t   [2:0] vec3_pos_t;
  typedef world_comp_t [2:0] vec3_world_t;

  typedef enum logic [1:0] {StIdle, StAdd, StHold} state_e;

endpackage

// File: rtl/cam_to_world_vec3_add_sat.sv
// Combinational 3-lane sign-extend, add and saturate; any clamped lane raises sat.
module cam_to_world_vec3_add_sat
  import cam_to_world_pkg::*;
(
  input  vec3_cam_t   a,
  input  vec3_pos_t   b,
  output vec3_world_t y,
  output logic        sat
);

  logic signed [SUM_W-1:0] sum [3];

  always_comb begin
    sat = 1'b0;
    y   = '0;
    for (int i = 0; i < 3; i++) begin
      sum[i] = {{(SUM_W - IN_W){a[i][IN_W-1]}}, a[i]}
             + {{(SUM_W - POS_W){b[i][POS_W-1]}}, b[i]};
      if (sum[i] > SUM_MAX) begin
        y[i] = SUM_MAX[OUT_W-1:0];
        sat  = 1'b1;
      end else if (sum[i] < SUM_MIN) begin
        y[i] = SUM_MIN[OUT_W-1:0];
        sat  = 1'b1;
      end else begin
        y[i] = sum[i][OUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cam_to_world.sv
// Adds the camera position back onto a camera-relative triangle, one vertex per cycle,
// producing saturated world-space vertices behind a valid/ready handshake.
module cam_to_world
  import cam_to_world_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic signed [POS_W-1:0] cam_pos_in [3],
  input  logic                    cam_load_in,
  input  logic                    tri_valid_in,
  output logic                    tri_ready_out,
  input  logic signed [IN_W-1:0]  v1_in [3],
  input  logic signed [IN_W-1:0]  v2_in [3],
  input  logic signed [IN_W-1:0]  v3_in [3],
  output logic                    tri_valid_out,
  input  logic                    tri_ready_in,
  output logic signed [OUT_W-1:0] v1_out [3],
  output logic signed [OUT_W-1:0] v2_out [3],
  output logic signed [OUT_W-1:0] v3_out [3],
  output logic                    clip_out,
  output logic                    busy_out
);

  state_e      state_q, state_d;
  vec3_pos_t   cam_q, pend_q, cam_new;
  logic        pending_q;
  logic [1:0]  idx_q;
  logic        clip_q;
  vec3_cam_t   vin_q [3];
  vec3_cam_t   tri_new [3];
  vec3_world_t vout_q [3];

  logic        accept, hold_done, add_en;
  vec3_cam_t   add_a;
  vec3_world_t add_y;
  logic        add_sat;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cam_new[i]    = cam_pos_in[i];
      tri_new[0][i] = v1_in[i];
      tri_new[1][i] = v2_in[i];
      tri_new[2][i] = v3_in[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    hold_done = 1'b0;
    add_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tri_valid_in) begin
          accept  = 1'b1;
          state_d = StAdd;
        end
      end
      StAdd: begin
        add_en = 1'b1;
        if (idx_q == 2'd2) state_d = StHold;
      end
      StHold: begin
        if (tri_ready_in) begin
          hold_done = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (idx_q)
      2'd0:    add_a = vin_q[0];
      2'd1:    add_a = vin_q[1];
      default: add_a = vin_q[2];
    endcase
  end

  cam_to_world_vec3_add_sat u_add (
    .a   (add_a),
    .b   (cam_q),
    .y   (add_y),
    .sat (add_sat)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      cam_q     <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      clip_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        vin_q[i]  <= '0;
        vout_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        vin_q  <= tri_new;
        clip_q <= 1'b0;
        idx_q  <= '0;
      end
      if (add_en) begin
        for (int i = 0; i < 3; i++) begin
          if (idx_q == 2'(i)) vout_q[i] <= add_y;
        end
        clip_q <= clip_q | add_sat;
        idx_q  <= idx_q + 2'd1;
      end
      // Loads seen mid-triangle are deferred so the in-flight triangle keeps its camera
      if (state_q == StIdle) begin
        if (cam_load_in) cam_q <= cam_new;
      end else if (hold_done) begin
        if (cam_load_in)    cam_q <= cam_new;
        else if (pending_q) cam_q <= pend_q;
        pending_q <= 1'b0;
      end else if (cam_load_in) begin
        pend_q    <= cam_new;
        pending_q <= 1'b1;
      end
    end
  end

  assign tri_ready_out = rst_n_in && (state_q == StIdle);
  assign tri_valid_out = (state_q == StHold);
  assign busy_out      = (state_q != StIdle);
  assign clip_out      = clip_q && (state_q == StHold);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      v1_out[i] = vout_q[0][i];
      v2_out[i] = vout_q[1][i];
      v3_out[i] = vout_q[2][i];
    end
  end

endmodule
